ysyx_2022040010_wb_arbiter: RTL

Writeback arbiter and register scoreboard for the single write port of the riscv64 integer register file. Two writeback requesters, the ALU pipe and the LSU, share that port. This block picks one per cycle, registers the chosen write onto the port, and tracks which architectural registers have a write still in flight. From that tracking it generates the issue stall for RAW and WAW hazards. It sits between decode/issue, the two execution units and the register file write port.

---
 rtl/ysyx_2022040010_wb_pkg.sv | 14 +
 rtl/ysyx_2022040010_scoreboard.sv | 58 +++++
 rtl/ysyx_2022040010_wb_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ysyx_2022040010_wb_pkg.sv
// Shared defaults and requester ids for the writeback arbiter slice.
package ysyx_2022040010_wb_pkg;

  localparam int unsigned WB_XLEN = 64;
  localparam int unsigned WB_NREG = 32;
  localparam int unsigned WB_AW   = 5;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_ALU  = 2'd1,
    REQ_LSU  = 2'd2
  } req_id_e;

endpackage

// File: rtl/ysyx_2022040010_scoreboard.sv
// Register busy bitmap with issue-side RAW/WAW stall generation.
module ysyx_2022040010_scoreboard
  import ysyx_2022040010_wb_pkg::*;
#(
  parameter int unsigned NREG = WB_NREG,
  parameter int unsigned AW   = WB_AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic            issue_we,
  input  logic [AW-1:0]   issue_rd,
  input  logic [AW-1:0]   issue_rs1,
  input  logic [AW-1:0]   issue_rs2,
  input  logic            rf_we,
  input  logic [AW-1:0]   rf_waddr,
  output logic            issue_stall,
  output logic [NREG-1:0] busy
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;
  logic            w_rs1_haz;
  logic            w_rs2_haz;
  logic            w_rd_haz;
  logic            w_issue_fire;

  // A register being written this cycle is readable through the regfile bypass.
  assign w_rs1_haz = r_busy[issue_rs1] && !(rf_we && (rf_waddr == issue_rs1)) && (issue_rs1 != '0);
  assign w_rs2_haz = r_busy[issue_rs2] && !(rf_we && (rf_waddr == issue_rs2)) && (issue_rs2 != '0);
  assign w_rd_haz  = issue_we && r_busy[issue_rd] && !(rf_we && (rf_waddr == issue_rd));

  assign issue_stall  = issue_valid && (w_rs1_haz || w_rs2_haz || w_rd_haz);
  assign w_issue_fire = issue_valid && issue_we && (issue_rd != '0) && !issue_stall;

  // Clear first so a same-cycle set for the next producer wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (rf_we) begin
      w_busy_nxt[rf_waddr] = 1'b0;
    end
    if (w_issue_fire) begin
      w_busy_nxt[issue_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign busy = r_busy;

endmodule

// File: rtl/ysyx_2022040010_wb_arbiter.sv
// Arbitrates ALU/LSU writebacks onto the single regfile write port and
// tracks in-flight destinations through the scoreboard.
module ysyx_2022040010_wb_arbiter
  import ysyx_2022040010_wb_pkg::*;
#(
  parameter int unsigned XLEN       = WB_XLEN,
  parameter int unsigned NREG       = WB_NREG,
  parameter int unsigned AW         = WB_AW,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic            issue_we,
  input  logic [AW-1:0]   issue_rd,
  input  logic [AW-1:0]   issue_rs1,
  input  logic [AW-1:0]   issue_rs2,
  output logic            issue_stall,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  output logic            rf_we,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [NREG-1:0] busy,
  output logic            err
);

  localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  req_id_e         w_grant;
  logic            w_alu_force;
  logic            w_fire;
  logic [AW-1:0]   w_fire_rd;
  logic [XLEN-1:0] w_fire_data;
  logic [SW-1:0]   r_starve_cnt;
  logic            r_rf_we;
  logic [AW-1:0]   r_rf_waddr;
  logic [XLEN-1:0] r_rf_wdata;
  logic            r_err;
  logic [NREG-1:0] w_busy;

  assign w_alu_force = (r_starve_cnt == SW'(STARVE_MAX));

  // LSU has priority unless the ALU has lost STARVE_MAX cycles in a row.
  always_comb begin
    w_grant = REQ_NONE;
    if (!rst) begin
      if (alu_valid && (w_alu_force || !lsu_valid)) begin
        w_grant = REQ_ALU;
      end else if (lsu_valid) begin
        w_grant = REQ_LSU;
      end
    end
  end

  always_comb begin
    w_fire      = 1'b0;
    w_fire_rd   = '0;
    w_fire_data = '0;
    case (w_grant)
      REQ_ALU: begin
        w_fire      = 1'b1;
        w_fire_rd   = alu_rd;
        w_fire_data = alu_data;
      end
      REQ_LSU: begin
        w_fire      = 1'b1;
        w_fire_rd   = lsu_rd;
        w_fire_data = lsu_data;
      end
      default: ;
    endcase
  end

  assign alu_ready = (w_grant == REQ_ALU);
  assign lsu_ready = (w_grant == REQ_LSU);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (alu_valid && !alu_ready) begin
      r_starve_cnt <= r_starve_cnt + SW'(1);
    end else begin
      r_starve_cnt <= '0;
    end
  end

  // Output stage: writes to x0 are accepted but never reach the regfile.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else begin
      r_rf_we <= w_fire && (w_fire_rd != '0);
      if (w_fire) begin
        r_rf_waddr <= w_fire_rd;
        r_rf_wdata <= w_fire_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_fire && (w_fire_rd != '0) && !w_busy[w_fire_rd]) begin
      r_err <= 1'b1;
    end
  end

  ysyx_2022040010_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_we    (issue_we),
    .issue_rd    (issue_rd),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .rf_we       (r_rf_we),
    .rf_waddr    (r_rf_waddr),
    .issue_stall (issue_stall),
    .busy        (w_busy)
  );

  assign rf_we    = r_rf_we;
  assign rf_waddr = r_rf_waddr;
  assign rf_wdata = r_rf_wdata;
  assign busy     = w_busy;
  assign err      = r_err;

endmodule
